// File: rtl/fft_io_sched.sv
// fft_io_sched: frame sequencer for the 2048-point radix-4 FFT core.
// Streams 2048 samples into the four RAM-A banks, kicks the FFT controller,
// waits for it to finish, then streams the results back out of RAM A.
module fft_io_sched #(
    parameter int RD_LAT    = 2,
    parameter int DIGIT_REV = 1
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iCLR,
    input  logic       iGO,
    input  logic       iIN_VALID,
    output logic       oIN_READY,
    output logic [1:0] oWR_BANK,
    output logic [8:0] oWR_ADDR,
    output logic       oWR_EN,
    output logic [1:0] oRD_BANK,
    output logic [8:0] oRD_ADDR,
    output logic       oRD_EN,
    output logic       oSEL_IO,
    output logic       oFFT_START,
    input  logic       iFFT_RDY,
    output logic       oOUT_VALID,
    output logic       oOUT_LAST,
    output logic       oBUSY
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        UNLOAD,
        DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [10:0]       r_cnt;
    logic [10:0]       r_k;
    logic              r_busySeen;
    logic [2:0]        r_drainCnt;
    logic [RD_LAT-1:0] r_vldPipe;
    logic [RD_LAT-1:0] r_lastPipe;

    logic              w_accept;
    logic              w_lastBeat;
    logic              w_rdEn;
    logic              w_lastRead;
    logic              w_drainDone;
    logic [10:0]       w_idx;

    assign w_accept    = (r_state == LOAD) && iIN_VALID;
    assign w_lastBeat  = w_accept && (r_cnt == 11'd2047);
    assign w_rdEn      = (r_state == UNLOAD);
    assign w_lastRead  = w_rdEn && (r_k == 11'd2047);
    assign w_drainDone = (r_drainCnt == 3'(RD_LAT - 1));

    // Unload index: base-4 digit reversal puts the results in natural frequency order.
    generate
        if (DIGIT_REV != 0) begin : g_digitRev
            assign w_idx = {r_k[0], r_k[2:1], r_k[4:3], r_k[6:5], r_k[8:7], r_k[10:9]};
        end else begin : g_storageOrder
            assign w_idx = r_k;
        end
    endgenerate

    // State register; async reset puts the sequencer back to power-up IDLE.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and RAM-port/handshake outputs; iCLR overrides every transition.
    always_comb begin
        w_nextState = r_state;
        oIN_READY   = 1'b0;
        oWR_EN      = 1'b0;
        oWR_BANK    = r_cnt[10:9];
        oWR_ADDR    = r_cnt[8:0];
        oRD_EN      = w_rdEn;
        oRD_BANK    = w_idx[10:9];
        oRD_ADDR    = w_idx[8:0];
        oSEL_IO     = 1'b1;
        oFFT_START  = 1'b0;
        oBUSY       = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (iGO) w_nextState = LOAD;
            end
            LOAD: begin
                oIN_READY = 1'b1;
                oWR_EN    = iIN_VALID;
                if (w_lastBeat) w_nextState = START;
            end
            START: begin
                oSEL_IO     = 1'b0;
                oFFT_START  = 1'b1;
                w_nextState = RUN;
            end
            RUN: begin
                oSEL_IO = 1'b0;
                if (r_busySeen && iFFT_RDY) w_nextState = UNLOAD;
            end
            UNLOAD: begin
                if (w_lastRead) w_nextState = DRAIN;
            end
            DRAIN: begin
                if (w_drainDone) w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (iCLR) w_nextState = IDLE;
    end

    // Load/unload counters, drain timer and the stale-ready guard for RUN.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_cnt      <= '0;
            r_k        <= '0;
            r_busySeen <= 1'b0;
            r_drainCnt <= '0;
        end else if (iCLR) begin
            r_cnt      <= '0;
            r_k        <= '0;
            r_busySeen <= 1'b0;
            r_drainCnt <= '0;
        end else begin
            if (w_accept) r_cnt <= r_cnt + 11'd1;
            if (w_rdEn) r_k <= r_k + 11'd1;
            if (r_state == START) begin
                r_busySeen <= 1'b0;
            end else if ((r_state == RUN) && !iFFT_RDY) begin
                r_busySeen <= 1'b1;
            end
            if (r_state == DRAIN) begin
                r_drainCnt <= r_drainCnt + 3'd1;
            end else begin
                r_drainCnt <= '0;
            end
        end
    end

    // Delay line that lines up valid/last with the RAM read data.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_vldPipe  <= '0;
            r_lastPipe <= '0;
        end else if (iCLR) begin
            r_vldPipe  <= '0;
            r_lastPipe <= '0;
        end else begin
            r_vldPipe[0]  <= w_rdEn;
            r_lastPipe[0] <= w_lastRead;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vldPipe[i]  <= r_vldPipe[i-1];
                r_lastPipe[i] <= r_lastPipe[i-1];
            end
        end
    end

    assign oOUT_VALID = r_vldPipe[RD_LAT-1];
    assign oOUT_LAST  = r_lastPipe[RD_LAT-1];

endmodule

// File: tb/tb_fft_io_sched.sv
// tb_fft_io_sched: directed frames through the FFT IO sequencer with a
// behavioural FFT controller; a storage-order instance rides along.
module tb_fft_io_sched;

    localparam int RD_LAT   = 2;
    localparam int FFT_BUSY = 3102;

    logic       iCLK = 1'b0;
    logic       iRESET;
    logic       iCLR;
    logic       iGO;
    logic       iIN_VALID;
    logic       iFFT_RDY;

    logic       oIN_READY, oWR_EN, oRD_EN, oSEL_IO, oFFT_START, oOUT_VALID, oOUT_LAST, oBUSY;
    logic [1:0] oWR_BANK, oRD_BANK;
    logic [8:0] oWR_ADDR, oRD_ADDR;

    logic       oIN_READYNat, oWR_ENNat, oRD_ENNat, oSEL_IONat, oFFT_STARTNat;
    logic       oOUT_VALIDNat, oOUT_LASTNat, oBUSYNat;
    logic [1:0] oWR_BANKNat, oRD_BANKNat;
    logic [8:0] oWR_ADDRNat, oRD_ADDRNat;

    int checkCount = 0;
    int passCount  = 0;
    int badStrobe  = 0;
    int startCount = 0;
    int dropDelay  = 1;

    fft_io_sched #(.RD_LAT(RD_LAT), .DIGIT_REV(1)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iCLR(iCLR), .iGO(iGO),
        .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY),
        .oWR_BANK(oWR_BANK), .oWR_ADDR(oWR_ADDR), .oWR_EN(oWR_EN),
        .oRD_BANK(oRD_BANK), .oRD_ADDR(oRD_ADDR), .oRD_EN(oRD_EN),
        .oSEL_IO(oSEL_IO), .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY),
        .oOUT_VALID(oOUT_VALID), .oOUT_LAST(oOUT_LAST), .oBUSY(oBUSY)
    );

    fft_io_sched #(.RD_LAT(RD_LAT), .DIGIT_REV(0)) dutNat (
        .iCLK(iCLK), .iRESET(iRESET), .iCLR(iCLR), .iGO(iGO),
        .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READYNat),
        .oWR_BANK(oWR_BANKNat), .oWR_ADDR(oWR_ADDRNat), .oWR_EN(oWR_ENNat),
        .oRD_BANK(oRD_BANKNat), .oRD_ADDR(oRD_ADDRNat), .oRD_EN(oRD_ENNat),
        .oSEL_IO(oSEL_IONat), .oFFT_START(oFFT_STARTNat), .iFFT_RDY(iFFT_RDY),
        .oOUT_VALID(oOUT_VALIDNat), .oOUT_LAST(oOUT_LASTNat), .oBUSY(oBUSYNat)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 iCLK = ~iCLK;

    // Mid-cycle watch on RAM strobe exclusivity and start pulses.
    always @(negedge iCLK) begin
        if (oWR_EN && oRD_EN) badStrobe++;
        if (!oSEL_IO && (oWR_EN || oRD_EN)) badStrobe++;
        if (oWR_ENNat && oRD_ENNat) badStrobe++;
        if (!oSEL_IONat && (oWR_ENNat || oRD_ENNat)) badStrobe++;
        if (oFFT_START) startCount++;
    end

    // Behavioural FFT controller: ready drops dropDelay cycles after start,
    // stays low FFT_BUSY cycles, then rises again.
    initial begin
        bit startSeen;
        int phase;
        int cnt;
        iFFT_RDY = 1'b1;
        phase    = 0;
        cnt      = 0;
        forever begin
            @(negedge iCLK);
            startSeen = oFFT_START;
            @(posedge iCLK);
            #1;
            if (startSeen) begin
                phase = 1;
                cnt   = 0;
            end
            if (phase == 1) begin
                cnt++;
                if (cnt == dropDelay) begin
                    iFFT_RDY = 1'b0;
                    phase    = 2;
                    cnt      = 0;
                end
            end else if (phase == 2) begin
                cnt++;
                if (cnt == FFT_BUSY) begin
                    iFFT_RDY = 1'b1;
                    phase    = 0;
                end
            end
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit go, input bit clr, input bit valid);
        iGO       = go;
        iCLR      = clr;
        iIN_VALID = valid;
    endtask

    task automatic nextCycle();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [29:0] packOutputs();
        return {oIN_READY, oWR_EN, oWR_BANK, oWR_ADDR, oRD_EN, oRD_BANK, oRD_ADDR,
                oFFT_START, oOUT_VALID, oOUT_LAST, oBUSY, oSEL_IO};
    endfunction

    function automatic logic [10:0] digitRev(input logic [10:0] k);
        return {k[0], k[2:1], k[4:3], k[6:5], k[8:7], k[10:9]};
    endfunction

    // Starts in IDLE; ends in the START cycle, or in IDLE after an abort.
    task automatic loadFrame(input bit toggle, input int abortBeat);
        int beat;
        int cyc;
        bit valid;
        beat = 0;
        cyc  = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        nextCycle();
        while (beat < 2048 && cyc < 10000) begin
            valid = toggle ? (cyc % 2 == 0) : 1'b1;
            applyStimulus(1'b0, valid && (beat == abortBeat), valid);
            #1;
            if (valid) begin
                checkOutput("loadWrite", {oIN_READY, oWR_EN, oWR_BANK, oWR_ADDR}, {2'b11, 11'(beat)});
            end else begin
                checkOutput("loadStall", {oIN_READY, oWR_EN}, 2'b10);
            end
            nextCycle();
            cyc++;
            if (valid) beat++;
            if (iCLR) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                #1;
                checkOutput("loadAbort", {oBUSY, oSEL_IO, oIN_READY, oWR_EN}, 4'b0100);
                return;
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("loadCycles", cyc, toggle ? 4095 : 2048);
        checkOutput("startPulse", {oFFT_START, oSEL_IO, oBUSY, oIN_READY}, 4'b1010);
    endtask

    // Starts in the START cycle; ends in the first UNLOAD cycle.
    task automatic waitRun(input bit holdGo);
        int runCycles;
        int selBad;
        runCycles = 0;
        selBad    = 0;
        nextCycle();
        applyStimulus(holdGo, 1'b0, 1'b0);
        #1;
        while (!oRD_EN && runCycles < 5000) begin
            if (oSEL_IO || !oBUSY || oFFT_START) selBad++;
            nextCycle();
            #1;
            runCycles++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("runCycles", runCycles, dropDelay + FFT_BUSY);
        checkOutput("runSelIo", selBad, 0);
    endtask

    // Starts in the first UNLOAD cycle; ends in IDLE.
    task automatic unloadFrame(input int abortK);
        bit          expRd, expVld, expLast, expBusy;
        logic [10:0] expIdx, actIdx, actNat, expNat;
        for (int c = 0; c <= 2048 + RD_LAT; c++) begin
            expRd   = (c < 2048);
            expVld  = (c >= RD_LAT) && (c < 2048 + RD_LAT);
            expLast = (c == 2047 + RD_LAT);
            expBusy = (c < 2048 + RD_LAT);
            expIdx  = expRd ? digitRev(11'(c)) : 11'd0;
            expNat  = expRd ? 11'(c) : 11'd0;
            actIdx  = oRD_EN ? {oRD_BANK, oRD_ADDR} : 11'd0;
            actNat  = oRD_ENNat ? {oRD_BANKNat, oRD_ADDRNat} : 11'd0;
            checkOutput("unloadRev", {oRD_EN, actIdx, oOUT_VALID, oOUT_LAST, oBUSY, oSEL_IO},
                        {expRd, expIdx, expVld, expLast, expBusy, 1'b1});
            checkOutput("unloadNat", {oRD_ENNat, actNat, oOUT_VALIDNat, oOUT_LASTNat},
                        {expRd, expNat, expVld, expLast});
            if (c == 1) begin
                checkOutput("revK1", {oRD_BANK, oRD_ADDR}, {2'd2, 9'd0});
                checkOutput("natK1", {oRD_BANKNat, oRD_ADDRNat}, {2'd0, 9'd1});
            end
            if (c == 2) begin
                checkOutput("revK2", {oRD_BANK, oRD_ADDR}, {2'd0, 9'd256});
            end
            if (c == abortK) begin
                iCLR = 1'b1;
                nextCycle();
                iCLR = 1'b0;
                #1;
                checkOutput("unloadAbort", {oBUSY, oSEL_IO, oRD_EN, oOUT_VALID, oOUT_LAST}, 5'b01000);
                return;
            end
            nextCycle();
            #1;
        end
    endtask

    // Main directed sequence.
    initial begin
        int s0;
        int resetBad;
        int quietBad;

        iRESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("resetValues", packOutputs(), 30'd1);
        iRESET = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("idleValues", packOutputs(), 30'd1);

        // iGO with iCLR in the same cycle stays in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("goClrIdle", {oBUSY, oIN_READY, oSEL_IO}, 3'b001);

        // Frame 1: continuous load, iGO held high through RUN.
        $display("[TB] frame 1: continuous load");
        dropDelay = 1;
        s0 = startCount;
        loadFrame(1'b0, -1);
        waitRun(1'b1);
        checkOutput("startOnce1", startCount - s0, 1);
        unloadFrame(-1);

        // Frame 2: stalled input and a stale ready at the start of RUN.
        $display("[TB] frame 2: toggling valid, stale ready");
        dropDelay = 4;
        s0 = startCount;
        loadFrame(1'b1, -1);
        waitRun(1'b0);
        checkOutput("startOnce2", startCount - s0, 1);
        unloadFrame(-1);

        // Frame 3: abort during load.
        $display("[TB] frame 3: abort at beat 700");
        dropDelay = 1;
        s0 = startCount;
        loadFrame(1'b0, 700);
        checkOutput("noStartAbort", startCount - s0, 0);

        // Frame 4: abort mid-unload.
        $display("[TB] frame 4: abort at k=1000");
        loadFrame(1'b0, -1);
        waitRun(1'b0);
        unloadFrame(1000);

        // Frame 5: asynchronous reset in the middle of RUN.
        $display("[TB] frame 5: async reset during RUN");
        s0 = startCount;
        loadFrame(1'b0, -1);
        repeat (50) nextCycle();
        iRESET = 1'b0;
        #1;
        checkOutput("asyncReset", packOutputs(), 30'd1);
        resetBad = 0;
        repeat (3) begin
            nextCycle();
            if (packOutputs() !== 30'd1) resetBad++;
        end
        checkOutput("resetHold", resetBad, 0);
        iRESET = 1'b1;
        quietBad = 0;
        repeat (20) begin
            nextCycle();
            if (oFFT_START || oBUSY || !oSEL_IO) quietBad++;
        end
        checkOutput("postResetQuiet", quietBad, 0);
        checkOutput("startOnce5", startCount - s0, 1);

        // Frame 6: a full frame after the aborts and reset.
        $display("[TB] frame 6: full frame after reset");
        s0 = startCount;
        loadFrame(1'b0, -1);
        waitRun(1'b0);
        checkOutput("startOnce6", startCount - s0, 1);
        unloadFrame(-1);

        checkOutput("strobeRules", badStrobe, 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
